// File: rtl/mux_collect_pkg.sv
// Shared defaults and state encoding for the lane-collecting mux.
package mux_collect_pkg;

    localparam int unsigned DATA_W_DEF    = 1;
    localparam int unsigned NUM_LANES_DEF = 8;
    localparam int unsigned SEL_W_DEF     = 3;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after ptr, wrapping.
module mux_rr_pick
    import mux_collect_pkg::*;
#(
    parameter int unsigned NUM_LANES = NUM_LANES_DEF,
    parameter int unsigned SEL_W     = SEL_W_DEF
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [SEL_W-1:0]     gnt_idx,
    output logic                 gnt_vld
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        cand    = ptr;
        gnt_idx = ptr;
        gnt_vld = 1'b0;
        for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                gnt_idx = cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_collect.sv
// Collects NUM_LANES valid/ready lanes into one registered, lane-tagged output stream.
// Define MUX_TDM_STRICT_EN for fixed time-division slots instead of work-conserving round-robin.
module mux_rr_collect
    import mux_collect_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned NUM_LANES = NUM_LANES_DEF,
    parameter int unsigned SEL_W     = SEL_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic [NUM_LANES-1:0]        in_valid,
    output logic [NUM_LANES-1:0]        in_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_valid,
    input  logic                        out_ready
);

    logic              state;
    logic              state_next;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  ptr_next;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic              load;
    logic              take;
    logic [DATA_W-1:0] lane_data;

`ifdef MUX_TDM_STRICT_EN
    assign gnt_idx = ptr;
    assign gnt_vld = in_valid[ptr];
`else
    mux_rr_pick #(
        .NUM_LANES (NUM_LANES),
        .SEL_W     (SEL_W)
    ) u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (load) state_next = gnt_vld ? ST_FULL : ST_EMPTY;
    end

    // Handshake decode; reset gates every grant so a held beat is simply dropped.
    always_comb begin
        load     = (state == ST_EMPTY) | out_ready;
        take     = reset & load & gnt_vld;
        in_ready = '0;
        if (take) in_ready = NUM_LANES'(1) << gnt_idx;
        ptr_next = ptr;
`ifdef MUX_TDM_STRICT_EN
        if (load) ptr_next = ptr + SEL_W'(1);
`else
        if (take) ptr_next = gnt_idx + SEL_W'(1);
`endif
    end

    always_comb begin
        lane_data = '0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            if (gnt_idx == SEL_W'(k)) lane_data = in_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            ptr       <= ptr_next;
            out_valid <= (state_next == ST_FULL);
            if (take) begin
                out_data <= lane_data;
                out_sel  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_collect.sv
// Directed self-checking bench for mux_rr_collect (default work-conserving build).
module tb_mux_rr_collect;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic [7:0] in_valid;
    logic [7:0] in_ready;
    logic [0:0] out_data;
    logic [2:0] out_sel;
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_collect #(
        .DATA_W    (1),
        .NUM_LANES (8),
        .SEL_W     (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] s, input logic d);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_sel"},   32'(out_sel),   32'(s));
        chk({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    logic [7:0] exp_rdy;
    int         lane;

    initial begin
        reset     = 1'b0;
        in_valid  = 8'hFF;
        in_data   = 8'h00;
        out_ready = 1'b1;

        // Reset held two edges with every lane requesting
        @(negedge clk);
        step();
        step();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h00);
        chk_out("rst", 1'b0, 3'd0, 1'b0);

        // Release: lane 0 first, then sweep all lanes with lane k data = k&1
        reset   = 1'b1;
        in_data = 8'hAA;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h01);
        step();
        chk_out("rel", 1'b1, 3'd0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            lane    = k % 8;
            exp_rdy = 8'(1) << lane;
            #1;
            chk("sweep_in_ready", 32'(in_ready), 32'(exp_rdy));
            step();
            chk_out("sweep", 1'b1, 3'(lane), 1'(lane & 1));
        end

        // ptr now 3: only lanes 2 and 5 -> 5 then 2 (wrap)
        in_valid = 8'b0010_0100;
        #1;
        chk("sparse_rdy5", 32'(in_ready), 32'h20);
        step();
        chk_out("sparse5", 1'b1, 3'd5, 1'b1);
        #1;
        chk("sparse_rdy2", 32'(in_ready), 32'h04);
        step();
        chk_out("sparse2", 1'b1, 3'd2, 1'b0);

        // Lanes 4 and 5 valid, ptr 3: grant 4, then stall five cycles
        in_valid = 8'b0011_0000;
        #1;
        chk("stall_pre_rdy", 32'(in_ready), 32'h10);
        step();
        chk_out("stall_pre", 1'b1, 3'd4, 1'b0);
        out_ready = 1'b0;
        in_data   = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'h00);
            step();
            chk_out("stall", 1'b1, 3'd4, 1'b0);
        end
        out_ready = 1'b1;
        in_data   = 8'hAA;
        #1;
        chk("unstall_rdy", 32'(in_ready), 32'h20);
        step();
        chk_out("unstall", 1'b1, 3'd5, 1'b1);

        // Only lane 3 valid, its data toggling every cycle
        in_valid = 8'h08;
        for (int k = 0; k < 6; k++) begin
            in_data = 8'((k & 1) << 3);
            #1;
            chk("lane3_rdy", 32'(in_ready), 32'h08);
            step();
            chk_out("lane3", 1'b1, 3'd3, 1'(k & 1));
        end

        // No valid lanes: output register empties
        in_valid = 8'h00;
        #1;
        chk("idle_rdy", 32'(in_ready), 32'h00);
        step();
        chk("idle_valid", 32'(out_valid), 32'h0);

        // Reset while a beat is held
        in_data  = 8'hAA;
        in_valid = 8'h40;
        #1;
        chk("pre_rst_rdy", 32'(in_ready), 32'h40);
        step();
        chk_out("pre_rst", 1'b1, 3'd6, 1'b0);
        reset    = 1'b0;
        in_valid = 8'hFF;
        #1;
        chk("midrst_rdy", 32'(in_ready), 32'h00);
        step();
        chk_out("midrst", 1'b0, 3'd0, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 8'(1) << k;
            #1;
            chk("post_rst_rdy", 32'(in_ready), 32'(exp_rdy));
            step();
            chk_out("post_rst", 1'b1, 3'(k), 1'(k & 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
